// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: six-digit multiplexed seven-segment scanner with guard gaps and frame-coherent snapshot
// Ports: clk, rst (sync, active-high); digits_in[23:0] packed BCD (digit 0 in [3:0]);
//        load captures digits_in; disp_en gates anodes; lzb_en blanks a zero hours-tens digit;
//        seg[6:0] active-low a..g (a = bit 6); an[5:0] active-low one-hot anodes;
//        frame_start pulses on the first drive cycle of digit 0.
module seg_scan_ctrl #(
    parameter int DWELL_CYC = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits_in,
    input  logic        load,
    input  logic        disp_en,
    input  logic        lzb_en,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        frame_start
);
    localparam int MAXC = DWELL_CYC > GUARD_CYC ? DWELL_CYC : GUARD_CYC;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;

    typedef enum logic {GUARD, DRIVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [23:0]   snapshot, snap_nxt, pend_buf;
    logic          pending, boundary, blank, off;
    logic [3:0]    dig;
    logic [6:0]    seg_nxt;
    logic [5:0]    an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b0000001;
        endcase
    endfunction

    // Outputs are registered from next-state values so they line up with the phase the state register enters.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        boundary  = 1'b0;
        if (state == GUARD && cnt == CW'(GUARD_CYC - 1)) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
            boundary  = (idx == 3'd0);
        end else if (state == DRIVE && cnt == CW'(DWELL_CYC - 1)) begin
            state_nxt = GUARD;
            cnt_nxt   = '0;
            idx_nxt   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
        // A load landing on the boundary edge bypasses the pending buffer.
        snap_nxt = !boundary ? snapshot : load ? digits_in : pending ? pend_buf : snapshot;
        dig      = snap_nxt[{idx_nxt, 2'b00} +: 4];
        blank    = idx_nxt == 3'd5 && lzb_en && snap_nxt[23:20] == 4'd0;
        off      = state_nxt == GUARD || blank;
        seg_nxt  = off ? 7'h7f : decode(dig);
        an_nxt   = (off || !disp_en) ? 6'h3f : ~(6'b1 << idx_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GUARD;
            cnt         <= '0;
            idx         <= 3'd0;
            snapshot    <= '0;
            pend_buf    <= '0;
            pending     <= 1'b0;
            seg         <= 7'h7f;
            an          <= 6'h3f;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            snapshot    <= snap_nxt;
            pend_buf    <= load ? digits_in : pend_buf;
            pending     <= boundary ? 1'b0 : (pending | load);
            seg         <= seg_nxt;
            an          <= an_nxt;
            frame_start <= boundary;
        end
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed display scanner for the six-digit HH:MM:SS seven-segment panel. It holds a frame-coherent snapshot of the six BCD digits and steps one shared BCD-to-seven-segment decode path across the digits. It drives one-hot active-low anode enables and inserts a guard gap between digits to suppress ghosting. It sits between the timekeeping counters and the display pins.

## Interface
- DWELL_CYC, default 50000: clocks each digit is driven; legal range ≥1.
- GUARD_CYC, default 500: clocks of all-off gap before each digit; legal range ≥1.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- digits_in  input  24  packed BCD. Bits [3:0] are seconds ones (digit 0). Bits [23:20] are hours tens (digit 5).
- load  input  1  one-cycle strobe; captures digits_in.
- disp_en  input  1  high = anodes may be driven. Low = anodes forced off while scanning continues.
- lzb_en  input  1  high = blank digit 5 when its value is 0.
- seg  output  7  active-low segments. a is bit 6, g is bit 0.
- an  output  6  active-low one-hot anode enables. Bit i is digit i.
- frame_start  output  1  one-cycle pulse on the first drive cycle of digit 0.

## Operation
- Reset is synchronous and active-high. While rst is high:
  - state = GUARD, idx = 0, cycle counter = 0.
  - snapshot = 0, pend_buf = 0, pending = 0.
  - seg = 7'b1111111, an = 6'b111111, frame_start = 0.
- rst asserted mid-frame aborts the frame immediately. The outputs above appear on the next clock edge.
- States:
  - GUARD: an = 111111, seg = 1111111. Lasts GUARD_CYC clocks, then goes to DRIVE for the current idx.
  - DRIVE: lasts DWELL_CYC clocks. Then idx increments modulo 6 (5 wraps to 0) and the state returns to GUARD.
- In DRIVE, an[idx] = 0 and all other bits are 1, gated by disp_en. If disp_en is low, an = 111111.
- In DRIVE, seg = decode(snapshot[4*idx+3:4*idx]):
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100.
  - 5 → 0100100, 6 → 0100000, 7 → 0001111, 8 → 0000000, 9 → 0000100.
  - Codes 10–15 → 0000001.
- Leading-zero blanking: when idx = 5, lzb_en = 1 and snapshot[23:20] = 0, then seg = 1111111 and an = 111111 for that slot. Slot timing is unchanged.
- Load and snapshot:
  - load = 1 writes digits_in into pend_buf and sets pending.
  - At each GUARD→DRIVE transition with idx = 0 (the frame boundary), pending = 1 copies pend_buf into snapshot and clears pending.
  - If load arrives on the frame-boundary cycle, snapshot takes digits_in that cycle directly and pending stays clear.
  - Back-to-back loads within one frame: the last one wins.
- The snapshot never changes mid-frame, so no mixed old/new digits are shown within a frame.

## Timing
- All outputs are registered. seg and an change on the same edge, never skewed.
- Cycle 0 is the first clock with rst low.
  - Cycles 0 to GUARD_CYC−1: guard.
  - Cycles GUARD_CYC to GUARD_CYC+DWELL_CYC−1: digit 0 driven.
  - frame_start = 1 only at cycle GUARD_CYC.
- Slot length is GUARD_CYC+DWELL_CYC. Frame length is 6·(GUARD_CYC+DWELL_CYC).
- frame_start period equals the frame length exactly.
- Load-to-display latency runs from the load edge to the next frame boundary:
  - maximum one frame length;
  - zero extra cycles if load falls on the boundary cycle.
- Counters are sized by $clog2 of max(DWELL_CYC, GUARD_CYC). They must not overflow.
- disp_en and lzb_en are sampled every cycle. Their effect is visible on the next edge.
- No combinational path from any input to any output.

## Test plan
Use DWELL_CYC = 4 and GUARD_CYC = 2 (slot = 6, frame = 36) for all scenarios.
- Reset then release: an = 111111 for 2 cycles, then an = 111110 with seg = 0000001 for 4 cycles, and frame_start high only on the first of those cycles. Then 2 guard cycles, then an = 111101.
- Load 24'h123459 mid-frame: the current frame still shows all zeros. From the next frame_start, slot 0 shows seg = 0000100 (9) and slot 5 shows seg = 1001111 (1). Over the full sweep, an is one-hot at most, and bits 0–5 are each low exactly 4 cycles per frame.
- Load on the exact frame-boundary cycle with 24'h000007: digit 0 shows 0001111 in that same frame. Two loads in one frame, 24'h000001 then 24'h000002: only 0010010 is displayed next frame.
- lzb_en = 1 with snapshot[23:20] = 0: slot 5 gives an = 111111 and seg = 1111111. With digit 5 = 1, it gives an = 011111 and seg = 1001111. Digit value 4'hC displays 0000001.
- disp_en = 0 for one full frame: an = 111111 throughout while frame_start keeps its 36-cycle period. Re-enabling resumes at the correct idx.
- rst pulse during digit 3 DRIVE: outputs go to reset values on the next edge, and snapshot clears. After release, the sequence restarts at guard then digit 0 showing 0.
